// File: rtl/log_pkg.sv
// Shared types and constants for the log-entry fetch path between the
// iDFI/CFI checkers and the PS-side memory read master.
package log_pkg;

    // Log table window: first and last valid entry start addresses.
    localparam logic [31:0] LOGTABLE_ADDRINIT = 32'h1FEF_F800;
    localparam logic [31:0] LOGTABLE_ADDREND  = 32'h1FEF_FBF0;

    // Entry geometry: three 32-bit words, ID / addr / data.
    localparam int LOG_ENTRY_BYTES    = 12;
    localparam int LOG_WIDTH          = 96;
    localparam int LOG_N_WORDS        = 3;
    localparam int LOG_TIMEOUT_CYCLES = 256;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_WORD = 2'b01,
        DONE    = 2'b10
    } log_state_e;

    // Entry address is usable only if word aligned and inside the table window.
    function automatic logic log_addr_ok(input logic [31:0] addr,
                                         input logic [31:0] lo,
                                         input logic [31:0] hi);
        return (addr[1:0] == 2'b00) && (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches the request vector starting at
// the pointer and returns the first asserted requester as one-hot and index.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Rotating priority search beginning at ptr; first hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && req[(int'(ptr) + i) % N_REQ]) begin
                any                                = 1'b1;
                grant[(int'(ptr) + i) % N_REQ]     = 1'b1;
                idx                                = IDX_W'((int'(ptr) + i) % N_REQ);
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/log_fetch_arbiter.sv
// Shares one single-word memory read port among N_REQ log consumers.
// Each granted request fetches a 3-word log entry and returns it as one
// 96-bit word {word0(ID), word1(addr), word2(data)}.
module log_fetch_arbiter #(
    parameter int          N_ADDR_WIDTH      = 32,
    parameter int          N_DATA_WIDTH      = 32,
    parameter int          N_REQ             = 2,
    parameter logic [31:0] LOGTABLE_ADDRINIT = log_pkg::LOGTABLE_ADDRINIT,
    parameter logic [31:0] LOGTABLE_ADDREND  = log_pkg::LOGTABLE_ADDREND,
    parameter int          N_WORDS_PER_LOG   = log_pkg::LOG_N_WORDS,
    parameter int          TIMEOUT_CYCLES    = log_pkg::LOG_TIMEOUT_CYCLES
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_REQ-1:0]                      i_rq,
    input  logic [N_REQ*N_ADDR_WIDTH-1:0]         i_addr,
    output logic [N_REQ-1:0]                      o_done,
    output logic                                  o_err,
    output logic [N_WORDS_PER_LOG*N_DATA_WIDTH-1:0] o_data,
    output logic                                  o_mem_rd_req,
    output logic [N_ADDR_WIDTH-1:0]               o_mem_addr,
    input  logic                                  i_mem_rd_ack,
    input  logic [N_DATA_WIDTH-1:0]               i_mem_rd_data
);

    import log_pkg::*;

    localparam int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WIDX_W   = (N_WORDS_PER_LOG > 1) ? $clog2(N_WORDS_PER_LOG) : 1;
    localparam int TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int ENTRY_W  = N_WORDS_PER_LOG * N_DATA_WIDTH;

    log_state_e             state_r;
    logic [IDX_W-1:0]       ptr_r;
    logic [IDX_W-1:0]       gnt_idx_r;
    logic [N_REQ-1:0]       gnt_oh_r;
    logic [WIDX_W-1:0]      word_idx_r;
    logic [TMR_W-1:0]       tmr_r;
    logic                   err_r;
    logic [ENTRY_W-1:0]     entry_r;

    logic [N_REQ-1:0]       arb_grant_s;
    logic [IDX_W-1:0]       arb_idx_s;
    logic                   arb_any_s;
    logic [N_ADDR_WIDTH-1:0] sel_addr_s;
    logic                   sel_addr_ok_s;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req   (i_rq),
        .ptr   (ptr_r),
        .grant (arb_grant_s),
        .idx   (arb_idx_s),
        .any   (arb_any_s)
    );

    // Address offered by the requester the arbiter currently favours, and its validity.
    always_comb begin
        sel_addr_s    = i_addr[arb_idx_s*N_ADDR_WIDTH +: N_ADDR_WIDTH];
        sel_addr_ok_s = log_addr_ok(sel_addr_s, LOGTABLE_ADDRINIT, LOGTABLE_ADDREND);
    end

    // Fetch sequencer: grant, walk the entry's words, then report on the granted lane.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= IDLE;
            ptr_r        <= '0;
            gnt_idx_r    <= '0;
            gnt_oh_r     <= '0;
            word_idx_r   <= '0;
            tmr_r        <= '0;
            err_r        <= 1'b0;
            entry_r      <= '0;
            o_done       <= '0;
            o_err        <= 1'b0;
            o_data       <= '0;
            o_mem_rd_req <= 1'b0;
            o_mem_addr   <= '0;
        end else begin
            // Completion flags are single-cycle pulses.
            o_done <= '0;
            o_err  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (arb_any_s) begin
                        gnt_idx_r  <= arb_idx_s;
                        gnt_oh_r   <= arb_grant_s;
                        word_idx_r <= '0;
                        tmr_r      <= '0;
                        if (sel_addr_ok_s) begin
                            err_r        <= 1'b0;
                            o_mem_rd_req <= 1'b1;
                            o_mem_addr   <= sel_addr_s;
                            state_r      <= RD_WORD;
                        end else begin
                            // Bad address never reaches the memory port.
                            err_r   <= 1'b1;
                            state_r <= DONE;
                        end
                    end
                end
                RD_WORD: begin
                    if (i_mem_rd_ack) begin
                        // word0 lands in the most significant slot.
                        entry_r[(N_WORDS_PER_LOG - 1 - int'(word_idx_r))*N_DATA_WIDTH +: N_DATA_WIDTH]
                            <= i_mem_rd_data;
                        tmr_r <= '0;
                        if (word_idx_r == WIDX_W'(N_WORDS_PER_LOG - 1)) begin
                            o_mem_rd_req <= 1'b0;
                            state_r      <= DONE;
                        end else begin
                            word_idx_r <= word_idx_r + WIDX_W'(1);
                            o_mem_addr <= o_mem_addr + N_ADDR_WIDTH'(4);
                        end
                    end else if (tmr_r == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        o_mem_rd_req <= 1'b0;
                        err_r        <= 1'b1;
                        state_r      <= DONE;
                    end else begin
                        tmr_r <= tmr_r + TMR_W'(1);
                    end
                end
                DONE: begin
                    o_done  <= gnt_oh_r;
                    o_err   <= err_r;
                    o_data  <= err_r ? '0 : entry_r;
                    ptr_r   <= (gnt_idx_r == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx_r + IDX_W'(1);
                    state_r <= IDLE;
                end
                default: begin
                    o_mem_rd_req <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_log_fetch_arbiter.sv
// Randomized self-checking bench for log_fetch_arbiter with a transaction-level
// reference model (round-robin pointer, address legality, expected entry).
module tb_log_fetch_arbiter;

    localparam logic [31:0] INIT = 32'h1FEF_F800;
    localparam logic [31:0] ENDA = 32'h1FEF_FBF0;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   i_rq;
    logic [63:0]  i_addr;
    logic [1:0]   o_done;
    logic         o_err;
    logic [95:0]  o_data;
    logic         o_mem_rd_req;
    logic [31:0]  o_mem_addr;
    logic         i_mem_rd_ack;
    logic [31:0]  i_mem_rd_data;

    int checks = 0;
    int errors = 0;
    int ptr_m  = 0;

    always #5 clk = ~clk;

    log_fetch_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .i_rq          (i_rq),
        .i_addr        (i_addr),
        .o_done        (o_done),
        .o_err         (o_err),
        .o_data        (o_data),
        .o_mem_rd_req  (o_mem_rd_req),
        .o_mem_addr    (o_mem_addr),
        .i_mem_rd_ack  (i_mem_rd_ack),
        .i_mem_rd_data (i_mem_rd_data)
    );

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One request from the model's point of view: grant, read words, done pulse.
    task automatic do_txn(input logic [1:0] mask, input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                          input int wait_n, input int withhold, input bit keep);
        int g;
        int k;
        int cyc;
        int widx;
        int cnt;
        bit seen;
        bit req_seen;
        bit ok;
        bit exp_err;
        logic [31:0] a;
        logic [31:0] words [3];
        logic [95:0] exp_data;
        words[0] = w0; words[1] = w1; words[2] = w2;
        g = -1;
        for (int i = 0; i < 2; i++) begin
            k = (ptr_m + i) % 2;
            if (g < 0 && mask[k]) g = k;
        end
        a        = (g == 0) ? a0 : a1;
        ok       = (a[1:0] == 2'b00) && (a >= INIT) && (a <= ENDA);
        exp_err  = !ok || (withhold >= 0);
        exp_data = exp_err ? 96'h0 : {w0, w1, w2};
        i_rq     = mask;
        i_addr   = {a1, a0};
        cyc = 0; widx = 0; cnt = 0; seen = 1'b0; req_seen = 1'b0;
        while (!seen && cyc < 600) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (!keep) i_rq = 2'b00;
            i_mem_rd_ack  = 1'b0;
            i_mem_rd_data = 32'h0;
            if (o_done != 2'b00) begin
                seen = 1'b1;
                check_val("done_vec", o_done, 128'(2'b01 << g));
                check_val("err", o_err, exp_err);
                check_val("data", o_data, exp_data);
                if (withhold < 0) check_val("latency", cyc, ok ? 5 + 3 * wait_n : 2);
            end else if (o_mem_rd_req) begin
                req_seen = 1'b1;
                if (ok && widx < 3) begin
                    check_val("mem_addr", o_mem_addr, a + 32'(4 * widx));
                    cnt++;
                    if (cnt > wait_n && widx != withhold) begin
                        i_mem_rd_ack  = 1'b1;
                        i_mem_rd_data = words[widx];
                        widx++;
                        cnt = 0;
                    end
                end
            end
        end
        if (!ok) check_val("no_mem_req", req_seen, 1'b0);
        if (!seen) check_val("done_timeout", 1'b0, 1'b1);
        else ptr_m = (g + 1) % 2;
        if (!keep) begin
            @(posedge clk);
            @(negedge clk);
            check_val("done_one_cycle", o_done, 2'b00);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        logic [31:0] v;
        r = $urandom_range(0, 9);
        v = INIT + 32'(4 * $urandom_range(0, 252));
        case (r)
            7:       return v + 32'd2;
            8:       return ENDA + 32'd4;
            9:       return INIT - 32'd4;
            6:       return ENDA;
            default: return v;
        endcase
    endfunction

    initial begin
        rst = 1'b0; i_rq = 2'b00; i_addr = 64'h0;
        i_mem_rd_ack = 1'b0; i_mem_rd_data = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_done", o_done, 2'b00);
        check_val("rst_err", o_err, 1'b0);
        check_val("rst_data", o_data, 96'h0);
        check_val("rst_req", o_mem_rd_req, 1'b0);
        check_val("rst_addr", o_mem_addr, 32'h0);
        rst = 1'b1;

        // Stray ack while idle must be ignored.
        i_mem_rd_ack = 1'b1; i_mem_rd_data = 32'hDEAD_BEEF;
        @(posedge clk); @(negedge clk);
        i_mem_rd_ack = 1'b0;
        check_val("idle_ack_done", o_done, 2'b00);
        check_val("idle_ack_req", o_mem_rd_req, 1'b0);

        // Basic fetch at the table start.
        do_txn(2'b01, 32'h1FEF_F800, 32'h0, 32'h3, 32'h24, 32'h50, 0, -1, 1'b0);
        check_val("t1_data", o_data, 96'h00000003_00000024_00000050);

        // Illegal addresses on requester 1.
        do_txn(2'b10, 32'h0, 32'h1FEF_F802, 32'h1, 32'h2, 32'h3, 0, -1, 1'b0);
        do_txn(2'b10, 32'h0, 32'h1FEF_FC00, 32'h1, 32'h2, 32'h3, 0, -1, 1'b0);

        // Both requesting continuously: strict rotation.
        for (int i = 0; i < 4; i++)
            do_txn(2'b11, INIT + 32'(16 * i), INIT + 32'(32 * i + 64),
                   32'(i + 10), 32'(i + 20), 32'(i + 30), 0, -1, (i < 3));

        // Ack withheld on word1 -> timeout, then a normal request.
        do_txn(2'b01, INIT + 32'h40, 32'h0, 32'h11, 32'h22, 32'h33, 0, 1, 1'b0);
        do_txn(2'b10, 32'h0, INIT + 32'h80, 32'hA1, 32'hA2, 32'hA3, 0, -1, 1'b0);

        // Last entry with waited acks.
        do_txn(2'b01, ENDA, 32'h0, 32'hC0FF_EE00, 32'h1FEF_FBFC, 32'h5555_AAAA, 2, -1, 1'b0);

        // Reset in the middle of a fetch on requester 1 (word index 1).
        i_rq = 2'b10; i_addr = {INIT + 32'h100, 32'h0};
        @(posedge clk); @(negedge clk);
        i_rq = 2'b00;
        check_val("mid_req", o_mem_rd_req, 1'b1);
        i_mem_rd_ack = 1'b1; i_mem_rd_data = 32'h7777_7777;
        @(posedge clk); @(negedge clk);
        i_mem_rd_ack = 1'b0;
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check_val("mid_rst_req", o_mem_rd_req, 1'b0);
        check_val("mid_rst_done", o_done, 2'b00);
        check_val("mid_rst_data", o_data, 96'h0);
        rst = 1'b1;
        ptr_m = 0;
        do_txn(2'b11, INIT + 32'h20, INIT + 32'h30, 32'h5, 32'h6, 32'h7, 0, -1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 30; i++)
            do_txn(2'($urandom_range(1, 3)), rand_addr(), rand_addr(),
                   $urandom(), $urandom(), $urandom(), $urandom_range(0, 2), -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
